// File: rtl/stage5_msg_fifo_k_module_if.sv
// Bus bundle between stage4 (master) and the stage-5 message FIFO (slave):
// three decoded lanes in, dictionary feedback, FWFT message stream out.
interface stage5_msg_fifo_k_module_if #(
   parameter int MSG_W = 280,
   parameter int CNT_W = 16
);
   logic [MSG_W-1:0] message_1;
   logic [MSG_W-1:0] message_2;
   logic [MSG_W-1:0] message_3;
   logic [2:0]       msg_valid_in;
   logic             in_ready;
   logic             dict_clr;
   logic [7:0]       field_PID1;
   logic [7:0]       field_MC1;
   logic [7:0]       field_MT1;
   logic [MSG_W-1:0] msg_out;
   logic             msg_valid;
   logic             msg_ready;
   logic [CNT_W-1:0] msg_count;

   modport master (
      output message_1, message_2, message_3, msg_valid_in, dict_clr, msg_ready,
      input  in_ready, field_PID1, field_MC1, field_MT1, msg_out, msg_valid, msg_count
   );

   modport slave (
      input  message_1, message_2, message_3, msg_valid_in, dict_clr, msg_ready,
      output in_ready, field_PID1, field_MC1, field_MT1, msg_out, msg_valid, msg_count
   );
endinterface

// File: rtl/stage5_msg_fifo_k_module.sv
// Stage-5 message FIFO: compacts up to three decoded lanes per cycle into a
// first-word-fall-through queue and maintains the copy-operator dictionary.
module stage5_msg_fifo_k_module #(
   parameter int MSG_W = 280,
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int CNT_W = 16
) (
   input logic                       clk,
   input logic                       rst_n,
   stage5_msg_fifo_k_module_if.slave bus
);
   typedef logic [AW-1:0]  ptr_t;
   typedef logic [AW:0]    cnt_t;
   typedef logic [CNT_W:0] sum_t;

   // Three free slots are needed so a full triple can always be absorbed
   localparam cnt_t THRESH = cnt_t'(DEPTH - 3);

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   logic [MSG_W-1:0] r_mem [DEPTH];
   ptr_t             r_rd_ptr;
   ptr_t             r_wr_ptr;
   cnt_t             r_count;
   logic [CNT_W-1:0] r_msg_count;
   logic [7:0]       r_pid;
   logic [7:0]       r_mc;
   logic [7:0]       r_mt;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_pop;
   logic [1:0]       w_n_push;
   ptr_t             w_addr1;
   ptr_t             w_addr2;
   ptr_t             w_addr3;
   logic [23:0]      w_dict_new;
   cnt_t             w_count_next;
   sum_t             w_cnt_sum;
   logic [CNT_W-1:0] w_msg_count_next;

   // Handshake decode, lane compaction offsets and next-state arithmetic
   always_comb begin
      w_in_ready = (r_count <= THRESH);
      w_accept   = w_in_ready & (|bus.msg_valid_in);
      w_pop      = (r_count != cnt_t'(1'b0)) & bus.msg_ready;
      w_n_push   = w_accept ? popcount3(bus.msg_valid_in) : 2'd0;
      w_addr1    = r_wr_ptr;
      w_addr2    = r_wr_ptr + ptr_t'(bus.msg_valid_in[0]);
      w_addr3    = r_wr_ptr + ptr_t'(popcount3({1'b0, bus.msg_valid_in[1:0]}));
      if (bus.msg_valid_in[2]) begin
         w_dict_new = bus.message_3[MSG_W-1 -: 24];
      end else if (bus.msg_valid_in[1]) begin
         w_dict_new = bus.message_2[MSG_W-1 -: 24];
      end else begin
         w_dict_new = bus.message_1[MSG_W-1 -: 24];
      end
      w_count_next = r_count + cnt_t'(w_n_push) - cnt_t'(w_pop);
      w_cnt_sum    = {1'b0, r_msg_count} + sum_t'(w_n_push);
      if (w_cnt_sum[CNT_W]) begin
         w_msg_count_next = {CNT_W{1'b1}};
      end else begin
         w_msg_count_next = w_cnt_sum[CNT_W-1:0];
      end
   end

   // Message storage; deliberately not cleared by reset
   always_ff @(posedge clk) begin
      if (rst_n && w_accept) begin
         if (bus.msg_valid_in[0]) r_mem[w_addr1] <= bus.message_1;
         if (bus.msg_valid_in[1]) r_mem[w_addr2] <= bus.message_2;
         if (bus.msg_valid_in[2]) r_mem[w_addr3] <= bus.message_3;
      end
   end

   // Pointer, occupancy and accepted-message counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_ptr    <= ptr_t'(1'b0);
         r_wr_ptr    <= ptr_t'(1'b0);
         r_count     <= cnt_t'(1'b0);
         r_msg_count <= {CNT_W{1'b0}};
      end else begin
         r_rd_ptr    <= r_rd_ptr + ptr_t'(w_pop);
         r_wr_ptr    <= r_wr_ptr + ptr_t'(w_n_push);
         r_count     <= w_count_next;
         r_msg_count <= w_msg_count_next;
      end
   end

   // Dictionary registers; a packet-boundary clear beats a same-cycle load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pid <= 8'h00;
         r_mc  <= 8'h00;
         r_mt  <= 8'h00;
      end else if (bus.dict_clr) begin
         r_pid <= 8'h00;
         r_mc  <= 8'h00;
         r_mt  <= 8'h00;
      end else if (w_accept) begin
         r_pid <= w_dict_new[23:16];
         r_mc  <= w_dict_new[15:8];
         r_mt  <= w_dict_new[7:0];
      end else begin
         r_pid <= r_pid;
         r_mc  <= r_mc;
         r_mt  <= r_mt;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.msg_valid  = (r_count != cnt_t'(1'b0));
   assign bus.msg_out    = r_mem[r_rd_ptr];
   assign bus.msg_count  = r_msg_count;
   assign bus.field_PID1 = r_pid;
   assign bus.field_MC1  = r_mc;
   assign bus.field_MT1  = r_mt;
endmodule

// File: tb/tb_stage5_msg_fifo_k_module.sv
// Randomised bench for the stage-5 message FIFO against a queue-based model
// of the lane-compaction, FWFT draining, dictionary and counter rules.
module tb_stage5_msg_fifo_k_module;
   localparam int MSG_W = 280;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int CNT_W = 16;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stage5_msg_fifo_k_module_if #(.MSG_W(MSG_W), .CNT_W(CNT_W)) bus ();

   stage5_msg_fifo_k_module #(
      .MSG_W(MSG_W), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [MSG_W-1:0] q [$];
   logic [7:0]       m_pid;
   logic [7:0]       m_mc;
   logic [7:0]       m_mt;
   int               m_cnt;
   int               n_cmp = 0;
   int               n_err = 0;
   int               serial = 0;

   task automatic check_val(input string tag, input logic [MSG_W-1:0] obs,
                            input logic [MSG_W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MSG_W-1:0] mk(input logic [23:0] tag);
      logic [MSG_W-1:0] m;
      for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
      m[MSG_W-1 -: 24] = tag;
      m[31:0] = serial;
      serial++;
      return m;
   endfunction

   // One clock: drive inputs, check outputs against the model, advance model
   task automatic cycle(input logic [2:0] v, input logic rdy, input logic clr,
                        input logic rst, input logic [23:0] t1,
                        input logic [23:0] t2, input logic [23:0] t3);
      logic [MSG_W-1:0] lanes [3];
      bit acc;
      lanes[0] = mk(t1);
      lanes[1] = mk(t2);
      lanes[2] = mk(t3);
      rst_n            = ~rst;
      bus.msg_valid_in = v;
      bus.msg_ready    = rdy;
      bus.dict_clr     = clr;
      bus.message_1    = lanes[0];
      bus.message_2    = lanes[1];
      bus.message_3    = lanes[2];
      @(negedge clk);
      check_val("in_ready", bus.in_ready, (q.size() <= DEPTH - 3));
      check_val("msg_valid", bus.msg_valid, (q.size() != 0));
      if (q.size() != 0) check_val("msg_out", bus.msg_out, q[0]);
      check_val("msg_count", bus.msg_count, m_cnt);
      check_val("field_PID1", bus.field_PID1, m_pid);
      check_val("field_MC1", bus.field_MC1, m_mc);
      check_val("field_MT1", bus.field_MT1, m_mt);
      if (rst) begin
         q.delete();
         m_pid = 8'h00; m_mc = 8'h00; m_mt = 8'h00;
         m_cnt = 0;
      end else begin
         acc = (q.size() <= DEPTH - 3) && (v != 3'b000);
         if (q.size() != 0 && rdy) void'(q.pop_front());
         if (acc) begin
            for (int i = 0; i < 3; i++) begin
               if (v[i]) begin
                  q.push_back(lanes[i]);
                  m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
               end
            end
         end
         if (clr) begin
            m_pid = 8'h00; m_mc = 8'h00; m_mt = 8'h00;
         end else if (acc) begin
            for (int i = 0; i < 3; i++) begin
               if (v[i]) {m_pid, m_mc, m_mt} = lanes[i][MSG_W-1 -: 24];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy);
      cycle(3'b000, rdy, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.msg_valid_in = 3'b000;
      bus.msg_ready    = 1'b0;
      bus.dict_clr     = 1'b0;
      bus.message_1    = '0;
      bus.message_2    = '0;
      bus.message_3    = '0;
      q.delete();
      m_pid = 8'h00; m_mc = 8'h00; m_mt = 8'h00; m_cnt = 0;
      repeat (2) @(posedge clk);
      #1;

      // Three lanes drained in lane order
      cycle(3'b111, 1'b1, 1'b0, 1'b0, 24'h111111, 24'h222222, 24'h333333);
      check_val("t1_pid", bus.field_PID1, 8'h33);
      check_val("t1_cnt", bus.msg_count, 16'd3);
      check_val("t1_head", bus.msg_out[MSG_W-1 -: 24], 24'h111111);
      repeat (3) idle(1'b1);

      // Gap compaction: lane1 then lane3
      cycle(3'b101, 1'b0, 1'b0, 1'b0, 24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC);
      check_val("t2_head", bus.msg_out[MSG_W-1 -: 24], 24'hAAAAAA);
      check_val("t2_mt", bus.field_MT1, 8'hCC);
      idle(1'b1);
      check_val("t2_second", bus.msg_out[MSG_W-1 -: 24], 24'hCCCCCC);
      idle(1'b1);

      // Threshold behaviour, full FIFO push+pop, pointer wrap
      cycle(3'b111, 1'b0, 1'b0, 1'b0, 24'h010101, 24'h020202, 24'h030303);
      cycle(3'b111, 1'b0, 1'b0, 1'b0, 24'h040404, 24'h050505, 24'h060606);
      check_val("t3_full_rdy", bus.in_ready, 1'b0);
      cycle(3'b111, 1'b0, 1'b0, 1'b0, 24'h070707, 24'h080808, 24'h090909);
      check_val("t3_ignored", bus.msg_count, 16'd11);
      idle(1'b1);
      check_val("t3_rdy_back", bus.in_ready, 1'b1);
      cycle(3'b111, 1'b0, 1'b0, 1'b0, 24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C);
      cycle(3'b111, 1'b1, 1'b0, 1'b0, 24'h0D0D0D, 24'h0E0E0E, 24'h0F0F0F);
      check_val("t4_cnt", bus.msg_count, 16'd14);
      idle(1'b1);
      idle(1'b1);
      for (int i = 0; i < 20; i++)
         cycle(3'b001, 1'b1, 1'b0, 1'b0, 24'($urandom), 24'h0, 24'h0);

      // Dictionary clear wins over accept, message still queued
      cycle(3'b001, 1'b0, 1'b1, 1'b0, 24'hAB1234, 24'h0, 24'h0);
      check_val("t5_pid", bus.field_PID1, 8'h00);
      check_val("t5_valid", bus.msg_valid, 1'b1);

      // Reset mid-operation
      cycle(3'b000, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h0);
      cycle(3'b111, 1'b0, 1'b0, 1'b0, 24'h123456, 24'h234567, 24'h345678);
      cycle(3'b011, 1'b0, 1'b0, 1'b0, 24'h456789, 24'h56789A, 24'h0);
      cycle(3'b000, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h0);
      check_val("t6_valid", bus.msg_valid, 1'b0);
      check_val("t6_rdy", bus.in_ready, 1'b1);
      check_val("t6_cnt", bus.msg_count, 16'd0);
      check_val("t6_mc", bus.field_MC1, 8'h00);

      // Randomised traffic
      for (int i = 0; i < 3000; i++)
         cycle(3'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 400) == 0),
               24'($urandom), 24'($urandom), 24'($urandom));

      // Saturate the accepted-message counter
      cycle(3'b000, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h0);
      for (int i = 0; i < 65600; i++)
         cycle(3'b111, 1'b1, 1'b0, 1'b0,
               24'($urandom), 24'($urandom), 24'($urandom));
      check_val("sat_cnt", bus.msg_count, 16'hFFFF);
      repeat (8) idle(1'b1);
      check_val("sat_hold", bus.msg_count, 16'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
